// File: rtl/rep_code_tx.sv
// Repetition-coded serial transmitter: start bit, DW data bits LSB first, stop bit,
// with every bit held on tx_o for REP chips so a REP-input majority voter can recover it.
module rep_code_tx #(
    parameter int DW  = 8,
    parameter int REP = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int CHIP_W = $clog2(REP);
    localparam int BIT_W  = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CHIP_W-1:0] CHIP_LAST = CHIP_W'(REP - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e            state_q;
    logic [CHIP_W-1:0] chip_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [DW-1:0]     shreg_q;
    logic [DW-1:0]     shreg_d;
    logic              tx_q;
    logic              done_q;
    logic              chip_last;

    assign chip_last = (chip_cnt_q == CHIP_LAST);
    assign shreg_d   = shreg_q >> 1;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chip_cnt_q <= '0;
            bit_cnt_q  <= '0;
            // NOTE: the shift register is cleared on reset too; it is a plain
            // register, not a memory, so resetting it costs nothing and keeps it defined.
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q    <= in_data;
                        chip_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end

                START: begin
                    if (chip_last) begin
                        chip_cnt_q <= '0;
                        tx_q       <= shreg_q[0];
                        state_q    <= DATA;
                    end else begin
                        chip_cnt_q <= chip_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (chip_last) begin
                        chip_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // tx_q loads the next bit from the shifted value so the
                            // new data chip starts right on the bit boundary.
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shreg_d[0];
                        end
                    end else begin
                        chip_cnt_q <= chip_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (chip_last) begin
                        chip_cnt_q <= '0;
                        tx_q       <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        chip_cnt_q <= chip_cnt_q + 1'b1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign tx_o     = tx_q;
    assign done_o   = done_q;

endmodule

// File: doc/rep_code_tx.md
REP_CODE_TX -- requirements
Module: rep_code_tx

Interface
- REQ-001: Parameter DW, default 8, data word width in bits; legal range 1..32.
- REQ-002: Parameter REP, default 5, number of serial chips per transmitted bit; SHALL be odd and >= 3, so it pairs with the team's REP-input majority voters.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst_n  input  1  reset; synchronous, active-low.
- REQ-005: in_valid  input  1  in_data holds a word to send.
- REQ-006: in_data  input  DW  word to transmit, sent LSB first.
- REQ-007: in_ready  output  1  block can accept a word this cycle.
- REQ-008: tx_o  output  1  serial chip stream; idle level is 1.
- REQ-009: busy_o  output  1  a frame is in progress.
- REQ-010: done_o  output  1  one-cycle pulse when a frame completes.

Function
- REQ-011: Frame format SHALL be 1 start bit (0), DW data bits (LSB first), then 1 stop bit (1); every bit is held on tx_o for exactly REP consecutive cycles (chips).
- REQ-012: Frame length SHALL be (DW+2)*REP cycles; for the defaults this is 50 cycles.
- REQ-013: The FSM SHALL have four states: IDLE, START, DATA, STOP.
- REQ-014: IDLE: in_ready=1, busy_o=0, tx_o=1; when in_valid=1 at a clock edge, the block latches in_data into a shift register and enters START.
- REQ-015: START: tx_o=0 for REP cycles, then the FSM enters DATA.
- REQ-016: DATA: tx_o = shift register bit 0 for REP cycles; then the register shifts right by 1 and the bit counter increments; after DW bits the FSM enters STOP.
- REQ-017: STOP: tx_o=1 for REP cycles, then the FSM enters IDLE.
- REQ-018: Latency: the first start chip SHALL appear on tx_o in the cycle immediately after the accepting edge.
- REQ-019: tx_o SHALL be driven from a register, so it never glitches combinationally.
- REQ-020: The chip counter SHALL count 0..REP-1 and wrap to 0 on each bit boundary; the bit counter SHALL count 0..DW-1; counter widths are sized with $clog2 and no overflow is reachable.
- REQ-021: in_ready SHALL be 0 in START, DATA and STOP; in_valid is ignored outside IDLE.
- REQ-022: Changes on in_data after acceptance SHALL NOT affect the frame in progress.
- REQ-023: busy_o SHALL be 1 exactly while the state is START, DATA or STOP.
- REQ-024: done_o SHALL be 1 for exactly one cycle: the first cycle back in IDLE after the last stop chip.
- REQ-025: Back-to-back frames: a word presented during that done_o cycle SHALL be accepted, giving a minimum inter-frame gap of 1 idle cycle (tx_o=1).
- REQ-026: If in_valid is held high continuously, words SHALL be accepted one per frame with no word dropped or duplicated.

Reset
- REQ-027: While rst_n=0 at a clock edge, the next state SHALL be: state=IDLE, counters=0, shift register=0, tx_o=1, in_ready=1, busy_o=0, done_o=0.
- REQ-028: Reset asserted mid-frame SHALL abort the frame without completing it, with no done_o pulse; tx_o is 1 from the cycle after the reset edge.
- REQ-029: in_valid SHALL be ignored while rst_n=0.

Verification
- REQ-030: Defaults, send 8'hA5 -> tx_o shows 5x0 start, then chip groups 1,0,1,0,0,1,0,1 (5 each), then 5x1 stop; busy_o is high for 50 cycles and done_o pulses in cycle 51.
- REQ-031: in_valid held high with words 8'h00 then 8'hFF -> two frames separated by exactly 1 idle cycle, with correct data groups in each.
- REQ-032: Assert rst_n=0 at cycle 20 of a frame -> tx_o=1, busy_o=0 and in_ready=1 after the reset edge; no done_o pulse.
- REQ-033: Change in_data every cycle during a frame carrying 8'h3C -> transmitted bits still decode to 8'h3C.
- REQ-034: Loop tx_o into a REP-chip sampler feeding the team's 5-input majority voter, with 1 chip per group flipped, for all 256 words -> every word recovered.
- REQ-035: Parameters DW=1, REP=3 -> frame length 9 cycles; pattern 000 b b b 111 for b = 0 and b = 1.
